// File: rtl/apu_pulse_bank.sv
// apu_pulse_bank: bank of NUM_CH pulse (square) channels with a registered mix.
// Each channel has a period timer, an 8-step duty sequencer, an envelope
// clocked by quarter-frame strobes and a length counter clocked by
// half-frame strobes. Channel registers are written over the APU register bus.
//
// Ports:
//   ACLK      APU clock, all state changes on the rising edge
//   RES       asynchronous active-high reset
//   wr_en     register write strobe (one cycle)
//   wr_addr   {channel index, register index[1:0]}
//   DB        register write data
//   en_mask   per-channel enable; a disabled channel holds its length at 0
//   qtr_tick  quarter-frame strobe (envelope clock)
//   half_tick half-frame strobe (length counter clock)
//   sq_out    registered 4-bit level per channel, channel i at [4i+3:4i]
//   lc_nz     per-channel length counter non-zero (combinational)
//   mix_out   registered unsigned sum of the sq_out levels
module apu_pulse_bank #(
  parameter int NUM_CH  = 4,
  parameter int TIMER_W = 11,
  parameter int ADDR_W  = $clog2(NUM_CH) + 2
) (
  input  logic                            ACLK,
  input  logic                            RES,
  input  logic                            wr_en,
  input  logic [ADDR_W-1:0]               wr_addr,
  input  logic [7:0]                      DB,
  input  logic [NUM_CH-1:0]               en_mask,
  input  logic                            qtr_tick,
  input  logic                            half_tick,
  output logic [4*NUM_CH-1:0]             sq_out,
  output logic [NUM_CH-1:0]               lc_nz,
  output logic [4+$clog2(NUM_CH+1)-1:0]   mix_out
);

  localparam int MIX_W = 4 + $clog2(NUM_CH + 1);

  logic [1:0]         duty_q   [NUM_CH];
  logic [1:0]         duty_d   [NUM_CH];
  logic               halt_q   [NUM_CH];
  logic               halt_d   [NUM_CH];
  logic               cnst_q   [NUM_CH];
  logic               cnst_d   [NUM_CH];
  logic [3:0]         vol_q    [NUM_CH];
  logic [3:0]         vol_d    [NUM_CH];
  logic [TIMER_W-1:0] period_q [NUM_CH];
  logic [TIMER_W-1:0] period_d [NUM_CH];
  logic [TIMER_W-1:0] timer_q  [NUM_CH];
  logic [TIMER_W-1:0] timer_d  [NUM_CH];
  logic [2:0]         step_q   [NUM_CH];
  logic [2:0]         step_d   [NUM_CH];
  logic               start_q  [NUM_CH];
  logic               start_d  [NUM_CH];
  logic [3:0]         decay_q  [NUM_CH];
  logic [3:0]         decay_d  [NUM_CH];
  logic [3:0]         div_q    [NUM_CH];
  logic [3:0]         div_d    [NUM_CH];
  logic [7:0]         len_q    [NUM_CH];
  logic [7:0]         len_d    [NUM_CH];

  logic [4*NUM_CH-1:0] sq_out_q, sq_out_d;
  logic [MIX_W-1:0]    mix_q, mix_d;
  logic [ADDR_W-1:0]   wr_ch;

  // Shift rather than slice so a single-channel build (no channel bits) still elaborates.
  assign wr_ch = wr_addr >> 2;

  // Pattern listed step 0..7 from MSB to LSB.
  function automatic logic duty_bit(input logic [1:0] duty, input logic [2:0] step);
    logic [7:0] pat;
    case (duty)
      2'b00:   pat = 8'b0100_0000;
      2'b01:   pat = 8'b0110_0000;
      2'b10:   pat = 8'b0111_1000;
      default: pat = 8'b1001_1111;
    endcase
    return pat[3'd7 - step];
  endfunction

  always_comb begin
    duty_d   = duty_q;
    halt_d   = halt_q;
    cnst_d   = cnst_q;
    vol_d    = vol_q;
    period_d = period_q;
    timer_d  = timer_q;
    step_d   = step_q;
    start_d  = start_q;
    decay_d  = decay_q;
    div_d    = div_q;
    len_d    = len_q;
    sq_out_d = '0;
    mix_d    = '0;
    lc_nz    = '0;

    for (int c = 0; c < NUM_CH; c++) begin
      if (timer_q[c] == '0) begin
        timer_d[c] = period_q[c];
        step_d[c]  = step_q[c] + 3'd1;
      end else begin
        timer_d[c] = timer_q[c] - TIMER_W'(1);
      end

      if (qtr_tick) begin
        if (start_q[c]) begin
          start_d[c] = 1'b0;
          decay_d[c] = 4'hF;
          div_d[c]   = vol_q[c];
        end else if (div_q[c] == 4'd0) begin
          div_d[c] = vol_q[c];
          if (decay_q[c] != 4'd0) decay_d[c] = decay_q[c] - 4'd1;
          else if (halt_q[c])     decay_d[c] = 4'hF;
        end else begin
          div_d[c] = div_q[c] - 4'd1;
        end
      end

      if (half_tick && !halt_q[c] && (len_q[c] != 8'd0))
        len_d[c] = len_q[c] - 8'd1;

      // Writes come after the envelope/length updates so a length load
      // beats a same-cycle decrement and a restart beats a same-cycle start clear.
      if (wr_en && (int'(wr_ch) == c)) begin
        case (wr_addr[1:0])
          2'd0: begin
            duty_d[c] = DB[7:6];
            halt_d[c] = DB[5];
            cnst_d[c] = DB[4];
            vol_d[c]  = DB[3:0];
          end
          2'd1: period_d[c][7:0] = DB;
          2'd2: begin
            for (int b = 8; b < TIMER_W; b++) period_d[c][b] = DB[b-8];
          end
          default: begin
            if (en_mask[c]) len_d[c] = {DB[7:3], 3'b111};
            start_d[c] = 1'b1;
            step_d[c]  = 3'd0;
          end
        endcase
      end

      if (!en_mask[c]) len_d[c] = 8'd0;

      lc_nz[c] = (len_q[c] != 8'd0);

      // Periods below 8 are ultrasonic and muted.
      if (duty_bit(duty_q[c], step_q[c]) && (len_q[c] != 8'd0) &&
          (period_q[c] >= TIMER_W'(8)))
        sq_out_d[4*c +: 4] = cnst_q[c] ? vol_q[c] : decay_q[c];

      mix_d = mix_d + MIX_W'(sq_out_q[4*c +: 4]);
    end
  end

  always_ff @(posedge ACLK or posedge RES) begin
    if (RES) begin
      for (int c = 0; c < NUM_CH; c++) begin
        duty_q[c]   <= '0;
        halt_q[c]   <= 1'b0;
        cnst_q[c]   <= 1'b0;
        vol_q[c]    <= '0;
        period_q[c] <= '0;
        timer_q[c]  <= '0;
        step_q[c]   <= '0;
        start_q[c]  <= 1'b0;
        decay_q[c]  <= '0;
        div_q[c]    <= '0;
        len_q[c]    <= '0;
      end
      sq_out_q <= '0;
      mix_q    <= '0;
    end else begin
      duty_q   <= duty_d;
      halt_q   <= halt_d;
      cnst_q   <= cnst_d;
      vol_q    <= vol_d;
      period_q <= period_d;
      timer_q  <= timer_d;
      step_q   <= step_d;
      start_q  <= start_d;
      decay_q  <= decay_d;
      div_q    <= div_d;
      len_q    <= len_d;
      sq_out_q <= sq_out_d;
      mix_q    <= mix_d;
    end
  end

  assign sq_out  = sq_out_q;
  assign mix_out = mix_q;

endmodule
